// File: rtl/scroll_sequencer_if.sv
// Handshake bundle between the game FSM and the scroll sequencer.
interface scroll_sequencer_if;
  logic       enable;
  logic       restart;
  logic [2:0] level;
  logic [2:0] world;
  logic       player_dead;
  logic       scroll_tick;
  logic [9:0] scroll_pos;
  logic       level_complete;
  logic [1:0] seq_state;

  modport master (
    output enable, restart, level, world, player_dead,
    input  scroll_tick, scroll_pos, level_complete, seq_state
  );

  modport slave (
    input  enable, restart, level, world, player_dead,
    output scroll_tick, scroll_pos, level_complete, seq_state
  );
endinterface

// File: rtl/scroll_sequencer.sv
// Paces level scrolling: per-difficulty step period, position tracking, level-complete pulse.
// Optional macro CHECKPOINT_EN rewinds scroll_pos to the last checkpoint when the player dies.
module scroll_sequencer #(
  parameter logic [23:0] BASE_PERIOD      = 24'd5000000,
  parameter logic [23:0] SPEED_STEP       = 24'd250000,
  parameter logic [23:0] MIN_PERIOD       = 24'd1000000,
  parameter logic [9:0]  LEVEL_LEN        = 10'd640,
  parameter int          LEVELS_PER_WORLD = 4,
  parameter logic [9:0]  CHECKPOINT_LEN   = 10'd160
) (
  input logic          clk,
  input logic          rst,
  scroll_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FREEZE = 2'd2,
    DONE   = 2'd3
  } state_t;

  if (MIN_PERIOD < 24'd2 || (LEVEL_LEN % CHECKPOINT_LEN) != 10'd0) begin : g_cfg_err
    $error("scroll_sequencer: MIN_PERIOD must be >= 2 and CHECKPOINT_LEN must divide LEVEL_LEN");
  end

  state_t      state_q, state_d;
  logic [23:0] presc_q, presc_d;
  logic [23:0] period_q, period_d;
  logic [9:0]  pos_q, pos_d;
  logic        tick_q, tick_d;
  logic        cmpl_q, cmpl_d;

  logic [5:0]  idx;
  logic [29:0] prod;
  logic [29:0] diff;
  logic [23:0] period_new;
  logic [9:0]  ckpt_pos;
  logic [9:0]  pos_inc;

  assign idx  = 6'(({3'b000, bus.world} * 6'(LEVELS_PER_WORLD)) + {3'b000, bus.level});
  assign prod = 30'(idx) * 30'(SPEED_STEP);
  assign diff = 30'(BASE_PERIOD) - prod;

  // Underflow or anything below the floor clamps to MIN_PERIOD.
  always_comb begin
    period_new = MIN_PERIOD;
    if (prod <= 30'(BASE_PERIOD) && diff >= 30'(MIN_PERIOD)) begin
      period_new = diff[23:0];
    end
  end

`ifdef CHECKPOINT_EN
  assign ckpt_pos = (pos_q / CHECKPOINT_LEN) * CHECKPOINT_LEN;
`else
  assign ckpt_pos = pos_q;
`endif

  assign pos_inc = pos_q + 10'd1;

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    period_d = period_q;
    pos_d    = pos_q;
    tick_d   = 1'b0;
    cmpl_d   = 1'b0;
    if (bus.restart) begin
      state_d = IDLE;
      presc_d = '0;
      pos_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          presc_d = '0;
          pos_d   = '0;
          if (bus.enable) begin
            state_d  = RUN;
            period_d = period_new;
          end
        end
        RUN: begin
          // Death beats an expiring prescaler: no tick that cycle.
          if (bus.player_dead) begin
            state_d = FREEZE;
            presc_d = '0;
            pos_d   = ckpt_pos;
          end else if (bus.enable) begin
            if (presc_q == period_q - 24'd1) begin
              presc_d = '0;
              pos_d   = pos_inc;
              tick_d  = 1'b1;
              if (pos_inc == LEVEL_LEN) begin
                cmpl_d  = 1'b1;
                state_d = DONE;
              end
            end else begin
              presc_d = presc_q + 24'd1;
            end
          end
        end
        FREEZE: begin
          presc_d = '0;
          if (!bus.player_dead) begin
            state_d = RUN;
          end
        end
        DONE: begin
          presc_d = '0;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      period_q <= BASE_PERIOD;
      pos_q    <= '0;
      tick_q   <= 1'b0;
      cmpl_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      period_q <= period_d;
      pos_q    <= pos_d;
      tick_q   <= tick_d;
      cmpl_q   <= cmpl_d;
    end
  end

  assign bus.scroll_tick    = tick_q;
  assign bus.scroll_pos     = pos_q;
  assign bus.level_complete = cmpl_q;
  assign bus.seq_state      = state_q;

endmodule

// File: tb/tb_scroll_sequencer.sv
// Directed scenarios plus a long randomized run against a cycle-level reference model.
module tb_scroll_sequencer;
  localparam int BASE = 10;
  localparam int STEP = 2;
  localparam int MINP = 4;
  localparam int LEN  = 8;
  localparam int LPW  = 4;
  localparam int CKP  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  scroll_sequencer_if bus();

  scroll_sequencer #(
    .BASE_PERIOD(24'd10), .SPEED_STEP(24'd2), .MIN_PERIOD(24'd4),
    .LEVEL_LEN(10'd8), .LEVELS_PER_WORLD(4), .CHECKPOINT_LEN(10'd4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: position derived from enabled cycles elapsed in the current run segment.
  int m_state = 0, m_pos = 0, m_cnt = 0, m_base = 0, m_period = BASE;
  bit m_tick = 1'b0, m_done = 1'b0;

  function automatic int ref_period(input int w, input int l);
    int p;
    p = BASE - (w * LPW + l) * STEP;
    if (p < MINP) p = MINP;
    return p;
  endfunction

  task automatic model_step();
    m_tick = 1'b0;
    m_done = 1'b0;
    if (rst) begin
      m_state = 0; m_pos = 0; m_cnt = 0; m_base = 0; m_period = BASE;
    end else if (bus.restart) begin
      m_state = 0; m_pos = 0; m_cnt = 0; m_base = 0;
    end else begin
      case (m_state)
        0: if (bus.enable) begin
          m_state = 1; m_cnt = 0; m_base = 0;
          m_period = ref_period(int'(bus.world), int'(bus.level));
        end
        1: if (bus.player_dead) begin
          m_state = 2;
`ifdef CHECKPOINT_EN
          m_pos = (m_pos / CKP) * CKP;
`endif
          m_cnt = 0; m_base = m_pos;
        end else if (bus.enable) begin
          m_cnt++;
          if (m_cnt % m_period == 0) begin
            m_pos  = m_base + m_cnt / m_period;
            m_tick = 1'b1;
            if (m_pos == LEN) begin
              m_done = 1'b1; m_state = 3;
            end
          end
        end
        2: if (!bus.player_dead) begin
          m_state = 1; m_cnt = 0; m_base = m_pos;
        end
        default: ;
      endcase
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int w, input int l);
    bus.restart = 1'b1; bus.enable = 1'b0; bus.player_dead = 1'b0;
    cyc();
    bus.restart = 1'b0;
    bus.world = 3'(w); bus.level = 3'(l); bus.enable = 1'b1;
    cyc();
    total++;
    if (bus.seq_state !== 2'd1) begin
      bad++; $display("FAIL start_run state=%0d want 1", bus.seq_state);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.enable = 1'b1; bus.restart = 1'b0; bus.player_dead = 1'b1;
    bus.world = 3'd0; bus.level = 3'd0;
    cyc(); cyc();
    total++; if (bus.scroll_tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b want 0", bus.scroll_tick); end
    total++; if (bus.scroll_pos !== 10'd0) begin bad++; $display("FAIL reset_pos got=%0d want 0", bus.scroll_pos); end
    total++; if (bus.level_complete !== 1'b0) begin bad++; $display("FAIL reset_cmpl got=%b want 0", bus.level_complete); end
    total++; if (bus.seq_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want 0", bus.seq_state); end
    rst = 1'b0; bus.enable = 1'b0; bus.player_dead = 1'b0;
    cyc();
  endtask

  task automatic test_nominal();
    int extra;
    start_run(0, 0);
    for (int c = 0; c <= 80; c++) begin
      if (c > 0) cyc();
      total++;
      if ({bus.scroll_tick, bus.scroll_pos, bus.level_complete} !==
          {(c > 0 && c % 10 == 0), 10'(c / 10), (c == 80)}) begin
        bad++;
        $display("FAIL nominal c=%0d got tick=%b pos=%0d cmpl=%b want tick=%b pos=%0d cmpl=%b",
                 c, bus.scroll_tick, bus.scroll_pos, bus.level_complete,
                 (c > 0 && c % 10 == 0), c / 10, (c == 80));
      end
    end
    total++; if (bus.seq_state !== 2'd3) begin bad++; $display("FAIL nominal_done state=%0d want 3", bus.seq_state); end
    extra = 0;
    repeat (50) begin cyc(); if (bus.scroll_tick) extra++; end
    total++; if (extra != 0 || bus.scroll_pos !== 10'd8) begin
      bad++; $display("FAIL nominal_hold ticks=%0d pos=%0d want 0 and 8", extra, bus.scroll_pos);
    end
  endtask

  task automatic test_period();
    int first, last, n;
    start_run(1, 1);
    first = -1; last = -1; n = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 10) begin bus.world = 3'd0; bus.level = 3'd0; end
      cyc();
      if (bus.scroll_tick) begin if (first < 0) first = c; last = c; n++; end
    end
    total++; if (first != 4 || last != 32 || n != 8) begin
      bad++; $display("FAIL period_floor first=%0d last=%0d n=%0d want 4 32 8", first, last, n);
    end
    start_run(0, 2);
    first = -1; last = -1;
    for (int c = 1; c <= 12; c++) begin
      cyc();
      if (bus.scroll_tick) begin if (first < 0) first = c; last = c; end
    end
    total++; if (first != 6 || last != 12) begin
      bad++; $display("FAIL period_six first=%0d last=%0d want 6 12", first, last);
    end
  endtask

  task automatic test_enable_pause();
    int n, ticks;
    start_run(0, 0);
    repeat (3) cyc();
    bus.enable = 1'b0; ticks = 0;
    repeat (7) begin cyc(); if (bus.scroll_tick) ticks++; end
    total++; if (ticks != 0 || bus.seq_state !== 2'd1) begin
      bad++; $display("FAIL pause ticks=%0d state=%0d want 0 1", ticks, bus.seq_state);
    end
    bus.enable = 1'b1; n = 0;
    do begin cyc(); n++; end while (!bus.scroll_tick && n < 30);
    total++; if (n != 7 || bus.scroll_pos !== 10'd1) begin
      bad++; $display("FAIL resume delay=%0d pos=%0d want 7 1", n, bus.scroll_pos);
    end
  endtask

  task automatic test_death();
    int n, want_pos;
`ifdef CHECKPOINT_EN
    want_pos = 4;
`else
    want_pos = 5;
`endif
    start_run(0, 0);
    repeat (59) cyc();
    total++; if (bus.scroll_pos !== 10'd5) begin bad++; $display("FAIL death_pre pos=%0d want 5", bus.scroll_pos); end
    bus.player_dead = 1'b1;
    cyc();
    total++; if ({bus.scroll_tick, bus.seq_state, bus.scroll_pos} !== {1'b0, 2'd2, 10'(want_pos)}) begin
      bad++; $display("FAIL death tick=%b state=%0d pos=%0d want 0 2 %0d",
                      bus.scroll_tick, bus.seq_state, bus.scroll_pos, want_pos);
    end
    repeat (3) cyc();
    bus.player_dead = 1'b0;
    cyc();
    total++; if (bus.seq_state !== 2'd1) begin bad++; $display("FAIL revive state=%0d want 1", bus.seq_state); end
    n = 0;
    do begin cyc(); n++; end while (!bus.scroll_tick && n < 30);
    total++; if (n != 10 || bus.scroll_pos !== 10'(want_pos + 1)) begin
      bad++; $display("FAIL revive_tick delay=%0d pos=%0d want 10 %0d", n, bus.scroll_pos, want_pos + 1);
    end
  endtask

  task automatic test_restart();
    start_run(0, 0);
    repeat (85) cyc();
    bus.restart = 1'b1; cyc(); bus.restart = 1'b0;
    total++; if ({bus.scroll_pos, bus.seq_state} !== {10'd0, 2'd0}) begin
      bad++; $display("FAIL restart_done pos=%0d state=%0d want 0 0", bus.scroll_pos, bus.seq_state);
    end
    start_run(0, 0);
    repeat (79) cyc();
    bus.restart = 1'b1; cyc(); bus.restart = 1'b0;
    total++; if ({bus.scroll_tick, bus.level_complete, bus.seq_state, bus.scroll_pos} !== {1'b0, 1'b0, 2'd0, 10'd0}) begin
      bad++; $display("FAIL restart_final tick=%b cmpl=%b state=%0d pos=%0d want 0 0 0 0",
                      bus.scroll_tick, bus.level_complete, bus.seq_state, bus.scroll_pos);
    end
  endtask

  task automatic test_reset_mid();
    int n, ticks;
    start_run(0, 0);
    repeat (30) cyc();
    total++; if (bus.scroll_pos !== 10'd3) begin bad++; $display("FAIL rstmid_pre pos=%0d want 3", bus.scroll_pos); end
    rst = 1'b1; cyc(); rst = 1'b0; bus.enable = 1'b0;
    total++; if ({bus.scroll_tick, bus.scroll_pos, bus.level_complete, bus.seq_state} !== 14'd0) begin
      bad++; $display("FAIL rstmid tick=%b pos=%0d cmpl=%b state=%0d want all 0",
                      bus.scroll_tick, bus.scroll_pos, bus.level_complete, bus.seq_state);
    end
    ticks = 0;
    repeat (12) begin cyc(); if (bus.scroll_tick) ticks++; end
    total++; if (ticks != 0 || bus.seq_state !== 2'd0) begin
      bad++; $display("FAIL rstmid_idle ticks=%0d state=%0d want 0 0", ticks, bus.seq_state);
    end
    bus.enable = 1'b1; cyc(); n = 0;
    do begin cyc(); n++; end while (!bus.scroll_tick && n < 30);
    total++; if (n != 10 || bus.scroll_pos !== 10'd1) begin
      bad++; $display("FAIL rstmid_resume delay=%0d pos=%0d want 10 1", n, bus.scroll_pos);
    end
  endtask

  task automatic test_random();
    int completes;
    completes = 0;
    for (int i = 0; i < 4000; i++) begin
      rst             = ($urandom_range(0, 499) == 0);
      bus.restart     = ($urandom_range(0, 199) == 0);
      bus.enable      = ($urandom_range(0, 3) != 0);
      bus.player_dead = ($urandom_range(0, 39) == 0);
      bus.world       = 3'($urandom_range(0, 7));
      bus.level       = 3'($urandom_range(0, 7));
      cyc();
      if (bus.level_complete) completes++;
      total++;
      if ({bus.scroll_tick, bus.scroll_pos, bus.level_complete, bus.seq_state} !==
          {m_tick, 10'(m_pos), m_done, 2'(m_state)}) begin
        bad++;
        $display("FAIL random i=%0d got tick=%b pos=%0d cmpl=%b st=%0d want tick=%b pos=%0d cmpl=%b st=%0d",
                 i, bus.scroll_tick, bus.scroll_pos, bus.level_complete, bus.seq_state,
                 m_tick, m_pos, m_done, m_state);
      end
    end
    total++; if (completes == 0) begin bad++; $display("FAIL random_complete got=%0d want >0", completes); end
    rst = 1'b0; bus.restart = 1'b0; bus.player_dead = 1'b0;
  endtask

  initial begin
    bus.enable = 1'b0; bus.restart = 1'b0; bus.player_dead = 1'b0;
    bus.world = 3'd0; bus.level = 3'd0;
    test_reset();
    test_nominal();
    test_period();
    test_enable_pause();
    test_death();
    test_restart();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
